key_scan: RTL and testbench

Debounced reader for the board's active-low push buttons, the input-side counterpart of the LED drivers. Each key gets a two-flop synchronizer, a per-key debounce state machine, a steady pressed level, and single-cycle press, release and long-press event pulses. It sits between the key pins and the application logic.

---
 rtl/key_scan_pkg.sv | 16 +
 rtl/key_debounce_ch.sv | 120 ++++++++++++
 rtl/key_scan.sv | 34 +++
 tb/tb_key_scan.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// Shared definitions for the debounced key reader: per-channel FSM encoding
// and the default cycle counts for a 50 MHz system clock.
package key_scan_pkg;

    typedef enum logic [1:0] {
        KS_IDLE     = 2'd0,
        KS_PRESS_DB = 2'd1,
        KS_PRESSED  = 2'd2,
        KS_REL_DB   = 2'd3
    } key_fsm_e;

    // 20 ms debounce and 1 s long-press at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_LONG_CYCLES     = 50_000_000;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchronizer, debounce FSM with debounce and hold
// counters, and registered level / press / release / long-press outputs.
module key_debounce_ch
    import key_scan_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [1:0]        sync;
    logic              s;
    key_fsm_e          state;
    key_fsm_e          state_next;
    logic [DB_W-1:0]   db_cnt;
    logic [DB_W-1:0]   db_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic              level_next;
    logic              press_next;
    logic              release_next;
    logic              long_next;

    // Synchronizer resets to "released" so leaving reset cannot fake a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], key_n};
        end
    end

    assign s = sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= KS_IDLE;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            state       <= state_next;
            db_cnt      <= db_next;
            hold_cnt    <= hold_next;
            key_state   <= level_next;
            key_press   <= press_next;
            key_release <= release_next;
            key_long    <= long_next;
        end
    end

    always_comb begin
        state_next = state;
        db_next    = db_cnt;
        hold_next  = hold_cnt;
        case (state)
            KS_IDLE: begin
                if (!s) begin
                    state_next = KS_PRESS_DB;
                    db_next    = '0;
                end
            end
            KS_PRESS_DB: begin
                if (s) begin
                    state_next = KS_IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_next = KS_PRESSED;
                    hold_next  = '0;
                end else begin
                    db_next = db_cnt + 1'b1;
                end
            end
            // hold_cnt saturates, so a bounce back into PRESSED never re-arms key_long
            KS_PRESSED: begin
                if (s) begin
                    state_next = KS_REL_DB;
                    db_next    = '0;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_next = hold_cnt + 1'b1;
                end
            end
            KS_REL_DB: begin
                if (!s) begin
                    state_next = KS_PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_next = KS_IDLE;
                end else begin
                    db_next = db_cnt + 1'b1;
                end
            end
            default: begin
                state_next = KS_IDLE;
            end
        endcase
    end

    always_comb begin
        level_next   = (state_next == KS_PRESSED) || (state_next == KS_REL_DB);
        press_next   = (state == KS_PRESS_DB) && (state_next == KS_PRESSED);
        release_next = (state == KS_REL_DB) && (state_next == KS_IDLE);
        long_next    = (state == KS_PRESSED) && (hold_cnt != HOLD_LAST)
                       && (hold_next == HOLD_LAST);
    end

endmodule

// File: rtl/key_scan.sv
// Debounced reader for active-low push buttons: one independent
// key_debounce_ch per key pin.
module key_scan
    import key_scan_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_n       (key_n[i]),
            .key_state   (key_state[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_scan.sv
// Scoreboard bench for key_scan: stimulus pushes expected pulse cycles into a
// queue; a negedge monitor matches every pulse the DUT emits against it.
module tb_key_scan;

    localparam int NK  = 4;
    localparam int DB  = 8;
    localparam int LG  = 32;
    // key_n driven just after edge c is sampled at c+1; pulse is seen after edge c+1+2+DB
    localparam int LAT = DB + 3;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;

    typedef struct {
        int kind;
        int ch;
        int lo;
        int hi;
    } ev_t;

    logic          clk;
    logic          rst_n;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_state;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_long;

    int  cyc = 0;
    int  tests_run = 0;
    int  tests_failed = 0;
    ev_t exp_q[$];

    key_scan #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        case (k)
            K_PRESS:   return "key_press";
            K_RELEASE: return "key_release";
            default:   return "key_long";
        endcase
    endfunction

    task automatic expect_event(input int kind, input int ch, input int lo, input int hi);
        ev_t e;
        e.kind = kind;
        e.ch   = ch;
        e.lo   = lo;
        e.hi   = hi;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [NK-1:0] value, output int issued);
        @(posedge clk);
        #1;
        key_n  = value;
        issued = cyc;
    endtask

    task automatic checkOutput(input string name, input logic [NK-1:0] actual,
                               input logic [NK-1:0] required);
        tests_run++;
        if (actual !== required) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b, required %b", name, actual, required);
        end
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor: every pulse must match a queued expectation; stale entries are misses
    always @(negedge clk) begin
        logic pulse;
        int   idx;
        if (rst_n) begin
            for (int ch = 0; ch < NK; ch++) begin
                for (int k = 0; k < 3; k++) begin
                    pulse = (k == K_PRESS) ? key_press[ch] :
                            (k == K_RELEASE) ? key_release[ch] : key_long[ch];
                    if (pulse) begin
                        idx = -1;
                        for (int i = 0; i < exp_q.size(); i++) begin
                            if (idx < 0 && exp_q[i].kind == k && exp_q[i].ch == ch) idx = i;
                        end
                        tests_run++;
                        if (idx < 0) begin
                            tests_failed++;
                            $display("[TB] FAIL unexpected %s ch%0d: pulse at cycle %0d, required none",
                                     kind_name(k), ch, cyc);
                        end else begin
                            if (cyc < exp_q[idx].lo || cyc > exp_q[idx].hi) begin
                                tests_failed++;
                                $display("[TB] FAIL %s ch%0d: pulse at cycle %0d, required cycle %0d..%0d",
                                         kind_name(k), ch, cyc, exp_q[idx].lo, exp_q[idx].hi);
                            end
                            exp_q.delete(idx);
                        end
                    end
                end
            end
        end
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].hi < cyc) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL missed %s ch%0d: none by cycle %0d, required cycle %0d..%0d",
                         kind_name(exp_q[i].kind), exp_q[i].ch, cyc, exp_q[i].lo, exp_q[i].hi);
                exp_q.delete(i);
            end
        end
    end

    initial begin
        int   c;
        int   r;
        int   f;
        logic pat [11];

        rst_n = 1'b0;
        key_n = '1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset key_state", key_state, 4'b0000);
        checkOutput("reset key_press", key_press, 4'b0000);
        checkOutput("reset key_release", key_release, 4'b0000);
        checkOutput("reset key_long", key_long, 4'b0000);

        // 1: clean press on key 0
        applyStimulus(4'b1110, c);
        expect_event(K_PRESS, 0, c + LAT, c + LAT);
        expect_event(K_LONG, 0, c + LAT + LG - 1, c + LAT + LG - 1);
        wait_cycle(c + LAT - 1);
        checkOutput("t1 state before accept", key_state, 4'b0000);
        wait_cycle(c + LAT);
        checkOutput("t1 state at accept", key_state, 4'b0001);
        wait_cycle(c + LAT + 5);
        checkOutput("t1 state held", key_state, 4'b0001);
        wait_cycle(c + 45);
        applyStimulus(4'b1111, r);
        expect_event(K_RELEASE, 0, r + LAT, r + LAT);
        wait_cycle(r + LAT - 1);
        checkOutput("t1 state before release", key_state, 4'b0001);
        wait_cycle(r + LAT);
        checkOutput("t1 state after release", key_state, 4'b0000);
        wait_cycle(r + 20);

        // 2: press bounce on key 1 (L3 H1 L5 H1 then steady low)
        pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        f = 0;
        for (int i = 0; i < 11; i++) applyStimulus(pat[i] ? 4'b1111 : 4'b1101, f);
        expect_event(K_PRESS, 1, f + LAT, f + LAT);
        expect_event(K_LONG, 1, f + LAT + LG - 1, f + LAT + LG - 1);
        wait_cycle(f + LAT - 1);
        checkOutput("t2 state during debounce", key_state, 4'b0000);
        wait_cycle(f + LAT);
        checkOutput("t2 state accepted", key_state, 4'b0010);
        wait_cycle(f + 45);
        applyStimulus(4'b1111, r);
        expect_event(K_RELEASE, 1, r + LAT, r + LAT);
        wait_cycle(r + 20);

        // 3: long press on key 2, held 100 cycles
        applyStimulus(4'b1011, c);
        expect_event(K_PRESS, 2, c + LAT, c + LAT);
        expect_event(K_LONG, 2, c + LAT + LG - 1, c + LAT + LG - 1);
        wait_cycle(c + 99);
        applyStimulus(4'b1111, r);
        expect_event(K_RELEASE, 2, r + LAT, r + LAT);
        wait_cycle(r + 20);

        // 4: release bounce on key 3; hold time is frozen while bouncing
        applyStimulus(4'b0111, c);
        expect_event(K_PRESS, 3, c + LAT, c + LAT);
        expect_event(K_LONG, 3, c + LAT + LG + 3, c + LAT + LG + 5);
        wait_cycle(c + 15);
        for (int i = 0; i < 5; i++) applyStimulus(4'b1111, r);
        applyStimulus(4'b0111, r);
        for (int i = 1; i <= 5; i++) begin
            wait_cycle(r + i);
            checkOutput("t4 state through bounce", key_state, 4'b1000);
        end
        wait_cycle(c + 60);
        applyStimulus(4'b1111, r);
        expect_event(K_RELEASE, 3, r + LAT, r + LAT);
        wait_cycle(r + 20);

        // 5: all keys pressed on the same edge
        applyStimulus(4'b0000, c);
        for (int ch = 0; ch < NK; ch++) begin
            expect_event(K_PRESS, ch, c + LAT, c + LAT);
            expect_event(K_LONG, ch, c + LAT + LG - 1, c + LAT + LG - 1);
        end
        wait_cycle(c + LAT);
        checkOutput("t5 state all", key_state, 4'b1111);
        wait_cycle(c + 50);
        applyStimulus(4'b1111, r);
        for (int ch = 0; ch < NK; ch++) expect_event(K_RELEASE, ch, r + LAT, r + LAT);
        wait_cycle(r + 20);

        // 6: asynchronous reset while key 0 is held pressed
        applyStimulus(4'b1110, c);
        expect_event(K_PRESS, 0, c + LAT, c + LAT);
        wait_cycle(c + 15);
        checkOutput("t6 state before reset", key_state, 4'b0001);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t6 async key_state", key_state, 4'b0000);
        checkOutput("t6 async key_press", key_press, 4'b0000);
        checkOutput("t6 async key_release", key_release, 4'b0000);
        checkOutput("t6 async key_long", key_long, 4'b0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        r = cyc;
        expect_event(K_PRESS, 0, r + LAT, r + LAT);
        expect_event(K_LONG, 0, r + LAT + LG - 1, r + LAT + LG - 1);
        wait_cycle(r + LAT - 1);
        checkOutput("t6 state re-debouncing", key_state, 4'b0000);
        wait_cycle(r + 45);
        applyStimulus(4'b1111, r);
        expect_event(K_RELEASE, 0, r + LAT, r + LAT);
        wait_cycle(r + 25);

        while (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL missed %s ch%0d: none by end, required cycle %0d..%0d",
                     kind_name(exp_q[0].kind), exp_q[0].ch, exp_q[0].lo, exp_q[0].hi);
            void'(exp_q.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
